// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : counter_pkg
// Description : Shared types and width helpers for the counter_mod slice.
// Revision    : 1.0 - initial release
// ============================================================================
package counter_pkg;

    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } counter_mode_t;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int ps_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/counter_prescale.sv
`default_nettype none
// ============================================================================
// Module      : counter_prescale
// Description : Enable divider; tick fires once per PRESCALE enabled cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_prescale
    import counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic enable,
    output logic tick
);

    generate
        if (PRESCALE == 1) begin : g_bypass
            logic w_unused;
            assign w_unused = clk ^ reset ^ clr;
            assign tick     = enable;
        end else begin : g_divide
            localparam int             PW     = ps_width(PRESCALE);
            localparam logic [PW-1:0]  c_LAST = PW'(PRESCALE - 1);

            logic [PW-1:0] phase_q;
            logic [PW-1:0] phase_d;

            // clr discards the current phase so the next tick needs a full period
            always_comb begin
                phase_d = phase_q;
                if (clr) begin
                    phase_d = '0;
                end else if (enable) begin
                    phase_d = (phase_q == c_LAST) ? '0 : phase_q + PW'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    phase_q <= '0;
                end else begin
                    phase_q <= phase_d;
                end
            end

            assign tick = enable && (phase_q == c_LAST);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/counter_mod.sv
`default_nettype none
// ============================================================================
// Module      : counter_mod
// Description : Up/down modulo counter with clear, clamped load, wrap or
//               saturate mode, optional prescaler and bound/rollover flags.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_mod
    import counter_pkg::*;
#(
    parameter int            WIDTH    = 8,
    parameter int            MAX      = 2**WIDTH - 1,
    parameter counter_mode_t MODE     = CNT_WRAP,
    parameter int            PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_min,
    output logic             rollover
);

    localparam logic [WIDTH-1:0] c_MAX_VAL = WIDTH'(MAX);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             rollover_q;
    logic             rollover_d;

    logic             w_tick;
    logic [WIDTH-1:0] w_load_clamped;
    logic [WIDTH:0]   w_inc;
    logic [WIDTH:0]   w_dec;
    logic             w_over;
    logic             w_under;

    counter_prescale #(
        .PRESCALE (PRESCALE)
    ) u_prescale (
        .clk    (clk),
        .reset  (reset),
        .clr    (clear | load),
        .enable (enable),
        .tick   (w_tick)
    );

    assign w_load_clamped = (load_val > c_MAX_VAL) ? c_MAX_VAL : load_val;

    // One extra bit so MAX == 2**WIDTH-1 still shows the crossing
    assign w_inc   = {1'b0, count_q} + {{WIDTH{1'b0}}, 1'b1};
    assign w_dec   = {1'b0, count_q} - {{WIDTH{1'b0}}, 1'b1};
    assign w_over  = (w_inc > {1'b0, c_MAX_VAL});
    assign w_under = w_dec[WIDTH];

    always_comb begin
        count_d    = count_q;
        rollover_d = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = w_load_clamped;
        end else if (w_tick) begin
            if (up) begin
                if (w_over) begin
                    rollover_d = 1'b1;
                    count_d    = (MODE == CNT_WRAP) ? '0 : c_MAX_VAL;
                end else begin
                    count_d = w_inc[WIDTH-1:0];
                end
            end else begin
                if (w_under) begin
                    rollover_d = 1'b1;
                    count_d    = (MODE == CNT_WRAP) ? c_MAX_VAL : '0;
                end else begin
                    count_d = w_dec[WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q    <= '0;
            rollover_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            rollover_q <= rollover_d;
        end
    end

    assign count    = count_q;
    assign rollover = rollover_q;
    assign at_max   = (count_q == c_MAX_VAL);
    assign at_min   = (count_q == '0);

endmodule
`default_nettype wire

// File: tb/tb_counter_mod.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_mod
// Description : Scoreboard bench for counter_mod across wrap, saturate and
//               prescaled configurations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_mod;
    import counter_pkg::*;

    typedef struct packed {
        logic [7:0] cnt;
        logic       roll;
    } exp_t;

    typedef struct packed {
        logic       rst;
        logic       en;
        logic       up;
        logic       clr;
        logic       ld;
        logic [7:0] lv;
        logic [7:0] ecnt;
        logic       eroll;
    } stim_t;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       enable   = 1'b0;
    logic       up       = 1'b0;
    logic       clear    = 1'b0;
    logic       load     = 1'b0;
    logic [7:0] load_val = 8'd0;

    logic [7:0] cnt_a, cnt_b, cnt_c;
    logic       max_a, max_b, max_c;
    logic       min_a, min_b, min_c;
    logic       roll_a, roll_b, roll_c;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    // A: MAX=9 wrap, B: MAX=5 saturate, C: MAX=9 wrap with PRESCALE=3
    counter_mod #(.WIDTH(8), .MAX(9), .MODE(CNT_WRAP), .PRESCALE(1)) u_dut_a (
        .clk(clk), .reset(reset), .enable(enable), .up(up), .clear(clear),
        .load(load), .load_val(load_val), .count(cnt_a), .at_max(max_a),
        .at_min(min_a), .rollover(roll_a));

    counter_mod #(.WIDTH(8), .MAX(5), .MODE(CNT_SAT), .PRESCALE(1)) u_dut_b (
        .clk(clk), .reset(reset), .enable(enable), .up(up), .clear(clear),
        .load(load), .load_val(load_val), .count(cnt_b), .at_max(max_b),
        .at_min(min_b), .rollover(roll_b));

    counter_mod #(.WIDTH(8), .MAX(9), .MODE(CNT_WRAP), .PRESCALE(3)) u_dut_c (
        .clk(clk), .reset(reset), .enable(enable), .up(up), .clear(clear),
        .load(load), .load_val(load_val), .count(cnt_c), .at_max(max_c),
        .at_min(min_c), .rollover(roll_c));

    function automatic stim_t mk(input int rst, input int en, input int u,
                                 input int clr, input int ld, input int lv,
                                 input int ec, input int er);
        stim_t s;
        s.rst   = (rst != 0);
        s.en    = (en != 0);
        s.up    = (u != 0);
        s.clr   = (clr != 0);
        s.ld    = (ld != 0);
        s.lv    = 8'(lv);
        s.ecnt  = 8'(ec);
        s.eroll = (er != 0);
        return s;
    endfunction

    task automatic apply(input stim_t s);
        @(negedge clk);
        reset    = s.rst;
        enable   = s.en;
        up       = s.up;
        clear    = s.clr;
        load     = s.ld;
        load_val = s.lv;
    endtask

    task automatic test_reset();
        exp_t e;
        apply(mk(0, 0, 0, 0, 1, 5, 0, 0));
        @(posedge clk);
        apply(mk(1, 1, 1, 0, 0, 0, 0, 0));
        sb.push_back({8'd0, 1'b0});
        @(posedge clk); #1;
        e = sb.pop_front();
        n_tests++; if (cnt_a !== e.cnt) begin n_fail++; $display("FAIL reset count_a got %0d expected %0d", cnt_a, e.cnt); end
        n_tests++; if (roll_a !== e.roll) begin n_fail++; $display("FAIL reset rollover_a got %0b expected %0b", roll_a, e.roll); end
        n_tests++; if (min_a !== 1'b1) begin n_fail++; $display("FAIL reset at_min_a got %0b expected 1", min_a); end
        n_tests++; if (max_a !== 1'b0) begin n_fail++; $display("FAIL reset at_max_a got %0b expected 0", max_a); end
        n_tests++; if (cnt_c !== e.cnt) begin n_fail++; $display("FAIL reset count_c got %0d expected %0d", cnt_c, e.cnt); end
    endtask

    task automatic test_basic_up();
        exp_t e;
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 1; i <= 10; i++) begin
            apply(mk(0, 1, 1, 0, 0, 0, i % 10, (i == 10) ? 1 : 0));
            sb.push_back({8'(i % 10), (i == 10)});
            @(posedge clk); #1;
            e = sb.pop_front();
            n_tests++; if (cnt_a !== e.cnt) begin n_fail++; $display("FAIL basic_up[%0d] count got %0d expected %0d", i, cnt_a, e.cnt); end
            n_tests++; if (roll_a !== e.roll) begin n_fail++; $display("FAIL basic_up[%0d] rollover got %0b expected %0b", i, roll_a, e.roll); end
            n_tests++; if (max_a !== (e.cnt == 8'd9)) begin n_fail++; $display("FAIL basic_up[%0d] at_max got %0b expected %0b", i, max_a, (e.cnt == 8'd9)); end
        end
    endtask

    task automatic test_down_wrap();
        stim_t t[3];
        exp_t  e;
        t = '{mk(1, 0, 0, 0, 0, 0, 0, 0),
              mk(0, 1, 0, 0, 0, 0, 9, 1),
              mk(0, 1, 0, 0, 0, 0, 8, 0)};
        foreach (t[i]) begin
            apply(t[i]);
            sb.push_back({t[i].ecnt, t[i].eroll});
            @(posedge clk); #1;
            e = sb.pop_front();
            n_tests++; if (cnt_a !== e.cnt) begin n_fail++; $display("FAIL down_wrap[%0d] count got %0d expected %0d", i, cnt_a, e.cnt); end
            n_tests++; if (roll_a !== e.roll) begin n_fail++; $display("FAIL down_wrap[%0d] rollover got %0b expected %0b", i, roll_a, e.roll); end
        end
    endtask

    task automatic test_saturate();
        stim_t t[11];
        exp_t  e;
        t = '{mk(1, 0, 0, 0, 0, 0, 0, 0),
              mk(0, 0, 1, 0, 1, 4, 4, 0),
              mk(0, 1, 1, 0, 0, 0, 5, 0),
              mk(0, 1, 1, 0, 0, 0, 5, 1),
              mk(0, 1, 1, 0, 0, 0, 5, 1),
              mk(0, 1, 0, 0, 0, 0, 4, 0),
              mk(0, 1, 0, 0, 0, 0, 3, 0),
              mk(0, 1, 0, 0, 0, 0, 2, 0),
              mk(0, 1, 0, 0, 0, 0, 1, 0),
              mk(0, 1, 0, 0, 0, 0, 0, 0),
              mk(0, 1, 0, 0, 0, 0, 0, 1)};
        foreach (t[i]) begin
            apply(t[i]);
            sb.push_back({t[i].ecnt, t[i].eroll});
            @(posedge clk); #1;
            e = sb.pop_front();
            n_tests++; if (cnt_b !== e.cnt) begin n_fail++; $display("FAIL saturate[%0d] count got %0d expected %0d", i, cnt_b, e.cnt); end
            n_tests++; if (roll_b !== e.roll) begin n_fail++; $display("FAIL saturate[%0d] rollover got %0b expected %0b", i, roll_b, e.roll); end
        end
    endtask

    task automatic test_load_priority();
        stim_t t[8];
        exp_t  e;
        t = '{mk(1, 0, 0, 0, 0, 0,   0, 0),
              mk(0, 0, 1, 0, 1, 200, 9, 0),
              mk(0, 0, 1, 1, 1, 3,   0, 0),
              mk(0, 0, 1, 0, 1, 6,   6, 0),
              mk(0, 0, 1, 1, 0, 0,   0, 0),
              mk(0, 1, 1, 0, 1, 3,   3, 0),
              mk(0, 1, 1, 0, 0, 0,   4, 0),
              mk(0, 1, 1, 0, 1, 9,   9, 0)};
        foreach (t[i]) begin
            apply(t[i]);
            sb.push_back({t[i].ecnt, t[i].eroll});
            @(posedge clk); #1;
            e = sb.pop_front();
            n_tests++; if (cnt_a !== e.cnt) begin n_fail++; $display("FAIL load_prio[%0d] count got %0d expected %0d", i, cnt_a, e.cnt); end
            n_tests++; if (roll_a !== e.roll) begin n_fail++; $display("FAIL load_prio[%0d] rollover got %0b expected %0b", i, roll_a, e.roll); end
            n_tests++; if (min_a !== (e.cnt == 8'd0)) begin n_fail++; $display("FAIL load_prio[%0d] at_min got %0b expected %0b", i, min_a, (e.cnt == 8'd0)); end
        end
    endtask

    task automatic test_prescale();
        logic [7:0] ec [16];
        logic       en [16];
        exp_t       e;
        ec = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd2, 8'd2, 8'd2, 8'd3,
               8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd4};
        en = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
               1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 16; i++) begin
            apply(mk(0, en[i] ? 1 : 0, 1, 0, 0, 0, ec[i], 0));
            sb.push_back({ec[i], 1'b0});
            @(posedge clk); #1;
            e = sb.pop_front();
            n_tests++; if (cnt_c !== e.cnt) begin n_fail++; $display("FAIL prescale[%0d] count got %0d expected %0d", i, cnt_c, e.cnt); end
            n_tests++; if (roll_c !== e.roll) begin n_fail++; $display("FAIL prescale[%0d] rollover got %0b expected %0b", i, roll_c, e.roll); end
        end
    endtask

    task automatic test_reset_mid();
        stim_t t[8];
        exp_t  e;
        t = '{mk(1, 0, 0, 0, 0, 0, 0, 0),
              mk(0, 0, 1, 0, 1, 7, 7, 0),
              mk(0, 1, 1, 0, 0, 0, 7, 0),
              mk(0, 1, 1, 0, 0, 0, 7, 0),
              mk(1, 1, 1, 0, 0, 0, 0, 0),
              mk(0, 1, 1, 0, 0, 0, 0, 0),
              mk(0, 1, 1, 0, 0, 0, 0, 0),
              mk(0, 1, 1, 0, 0, 0, 1, 0)};
        foreach (t[i]) begin
            apply(t[i]);
            sb.push_back({t[i].ecnt, t[i].eroll});
            @(posedge clk); #1;
            e = sb.pop_front();
            n_tests++; if (cnt_c !== e.cnt) begin n_fail++; $display("FAIL reset_mid[%0d] count got %0d expected %0d", i, cnt_c, e.cnt); end
            n_tests++; if (roll_c !== e.roll) begin n_fail++; $display("FAIL reset_mid[%0d] rollover got %0b expected %0b", i, roll_c, e.roll); end
        end
    endtask

    task automatic test_back_to_back();
        stim_t t[6];
        exp_t  e;
        t = '{mk(1, 0, 0, 0, 0, 0, 0, 0),
              mk(0, 0, 1, 0, 1, 5, 5, 0),
              mk(0, 1, 1, 0, 0, 0, 6, 0),
              mk(0, 1, 0, 0, 0, 0, 5, 0),
              mk(0, 1, 0, 0, 0, 0, 4, 0),
              mk(0, 1, 1, 0, 0, 0, 5, 0)};
        foreach (t[i]) begin
            apply(t[i]);
            sb.push_back({t[i].ecnt, t[i].eroll});
            @(posedge clk); #1;
            e = sb.pop_front();
            n_tests++; if (cnt_a !== e.cnt) begin n_fail++; $display("FAIL back_to_back[%0d] count got %0d expected %0d", i, cnt_a, e.cnt); end
            n_tests++; if (roll_a !== e.roll) begin n_fail++; $display("FAIL back_to_back[%0d] rollover got %0b expected %0b", i, roll_a, e.roll); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        test_reset();
        test_basic_up();
        test_down_wrap();
        test_saturate();
        test_load_priority();
        test_prescale();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
